fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined ARM CPU. Holds the program counter, drives the combinational instruction ROM's byte address, and captures the returned word plus its PC into the IF/ID pipeline register. Accepts stall from the hazard unit and redirects from branch resolution, with an optional one-instruction delay slot. Detects out-of-range or misaligned fetch addresses and halts in a sticky fault state.

## Interface

Parameters:
- IMEM_BYTES, 1024, ROM size in bytes; power of two, > 4.
- RESET_PC, 64'h0, PC loaded on reset; word-aligned.
- DELAY_SLOT, 1, 1 = the instruction fetched in the redirect cycle is kept; 0 = it is squashed.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  64  byte address to the ROM; equals PC.
- imem_instr  in  32  ROM read data, combinational from imem_addr.
- stall  in  1  hold PC and IF/ID this cycle.
- br_taken  in  1  redirect request, single-cycle pulse.
- br_target  in  64  redirect byte address; valid when br_taken=1.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_pc  out  64  PC of the IF/ID instruction.
- if_id_instr  out  32  the IF/ID instruction word.
- fault  out  1  sticky; fetch address was misaligned or out of range.

## Operation

- States: RUN, PEND (redirect waiting on stall), FAULT.
- Reset values: pc=RESET_PC, if_id_valid=0, if_id_pc=0, if_id_instr=0, fault=0, pend_target=0, state=RUN.
- Address legality: legal(a) = (a[1:0]==0) && (a+3 < IMEM_BYTES), computed in 64 bits with no wrap.
- RUN, stall=0, br_taken=0: IF/ID <= {1, pc, imem_instr}; pc <= pc+4.
- RUN, stall=0, br_taken=1: pc <= br_target. IF/ID <= {DELAY_SLOT, pc, imem_instr}; when DELAY_SLOT=0, pc and instr are still written, only valid is cleared.
- RUN, stall=1, br_taken=0: pc and IF/ID hold.
- RUN, stall=1, br_taken=1: pc and IF/ID hold; pend_target <= br_target; go to PEND.
- PEND, stall=1: hold. A new br_taken overwrites pend_target (last request wins).
- PEND, stall=0: behave exactly as RUN with br_taken=1 and target pend_target (or br_target if br_taken is asserted that cycle, which takes precedence); go to RUN.
- Fault entry, checked before any PC write: the next PC value (pc+4 or redirect target) is not legal → go to FAULT, fault <= 1, pc holds. The current instruction is still captured per the rules above.
- FAULT: pc and all registers frozen except if_id_valid <= 0 on the first cycle with stall=0. Inputs are ignored. Exit only via rst_n.
- RESET_PC must itself be legal; the bench flags violations via assertion.

## Timing

- imem_addr is a direct register output: no combinational path from any input.
- Fetch-to-IF/ID latency is one edge. After rst_n deasserts, the first posedge loads instruction @RESET_PC with if_id_valid=1.
- Redirect: target appears on imem_addr one edge after br_taken is sampled with stall=0. The target instruction appears in IF/ID on the following edge.
- Stall is honoured in the same cycle it is sampled: no edge advances while stall=1.
- Asserting rst_n mid-operation clears all state immediately (asynchronously), including PEND and FAULT. No pending redirect survives reset.

## Structure

- Package fetch_pkg holds:
  - state enum fetch_state_t {RUN, PEND, FAULT}
  - INSTR_W=32, ADDR_W=64
  - function addr_legal(addr, bytes)
- Sub-module if_id_reg: IF/ID pipeline register with async active-low reset, load enable, and valid-clear input. It is reused by later stage registers.
- The PC, the pending-target register, and the FSM live in fetch_stage.

## Test plan

- Reset then 4 free-running cycles with ROM words A,B,C,D at 0,4,8,12 → IF/ID shows (0,A),(4,B),(8,C),(12,D), all valid; imem_addr reaches 16.
- stall high for 3 cycles at pc=8 → imem_addr stays 8 and IF/ID stays (4,B); on release, (8,C) is captured.
- br_taken with br_target=0x40 at pc=12 → DELAY_SLOT=1 captures (12,D) valid, then (0x40,word@0x40). DELAY_SLOT=0 captures with if_id_valid=0, then (0x40,…).
- br_taken=0x80 during stall, then br_taken=0x90 while still stalled, then release → imem_addr goes to 0x90; 0x80 is never fetched.
- br_target=0x42, and separately br_target=IMEM_BYTES-2 → fault=1 next edge, pc frozen, if_id_valid=0 thereafter. rst_n pulse low clears fault and restarts at RESET_PC.
- Run sequentially to pc=IMEM_BYTES-4 → that word is captured valid, then fault=1. Drop rst_n between clock edges in PEND → all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types, widths and helpers for the instruction-fetch
//               stage and the pipeline registers that follow it.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  // A fetch address is legal when it is word aligned and the whole word lies
  // inside the ROM. The sum is formed one bit wider so an address near the
  // top of the 64-bit space cannot wrap around and look legal.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] bytes);
    logic [ADDR_W:0] w_last;
    w_last = {1'b0, addr} + (ADDR_W+1)'(3);
    return (addr[1:0] == 2'b00) && (w_last < {1'b0, bytes});
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : Generic pipeline register holding {valid, pc, instr}.
//               load      - capture valid_d/pc_d/instr_d on the next edge
//               clr_valid - clear only the valid bit (load has priority)
//               rst_n     - asynchronous active-low reset, clears all fields
// Ports       : clk, rst_n, load, clr_valid, valid_d, pc_d, instr_d in;
//               valid_q, pc_q, instr_q out.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg #(
  parameter int PC_W   = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clr_valid,
  input  logic              valid_d,
  input  logic [PC_W-1:0]   pc_d,
  input  logic [DATA_W-1:0] instr_d,
  output logic              valid_q,
  output logic [PC_W-1:0]   pc_q,
  output logic [DATA_W-1:0] instr_q
);

  logic              r_valid;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (load) begin
      r_valid <= valid_d;
      r_pc    <= pc_d;
      r_instr <= instr_d;
    end else if (clr_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_q = r_valid;
  assign pc_q    = r_pc;
  assign instr_q = r_instr;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Holds the PC, addresses the
//               combinational instruction ROM and captures {pc, instr} into
//               the IF/ID register. Honours stall, buffers a redirect that
//               arrives while stalled, and halts in a sticky fault state when
//               the next fetch address would be misaligned or out of range.
// Ports       : clk, rst_n (async, active low)
//               imem_addr  -> ROM byte address (= PC, registered)
//               imem_instr <- ROM read data
//               stall, br_taken, br_target <- hazard / branch resolution
//               if_id_valid, if_id_pc, if_id_instr -> IF/ID register
//               fault -> sticky illegal-fetch flag
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               if_id_valid,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               fault
);

  localparam logic [ADDR_W-1:0] c_IMEM_BYTES = ADDR_W'(IMEM_BYTES);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pend_target;
  logic              r_fault;

  logic              w_redirect;
  logic [ADDR_W-1:0] w_redir_target;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_next_legal;
  logic              w_load;
  logic              w_clr_valid;
  logic              w_valid_in;

  // Next-PC selection. In PEND the buffered target is used unless a fresh
  // redirect arrives in the release cycle, which is newer and wins.
  always_comb begin
    w_redirect     = 1'b0;
    w_redir_target = br_target;
    w_load         = 1'b0;
    w_clr_valid    = 1'b0;
    case (r_state)
      RUN: begin
        w_redirect = br_taken;
        w_load     = !stall;
      end
      PEND: begin
        w_redirect     = 1'b1;
        w_redir_target = br_taken ? br_target : r_pend_target;
        w_load         = !stall;
      end
      FAULT: begin
        w_clr_valid = !stall;
      end
      default: ;
    endcase
    // The instruction fetched in a redirect cycle is the delay slot.
    w_valid_in   = w_redirect ? DELAY_SLOT : 1'b1;
    w_next_pc    = w_redirect ? w_redir_target : (r_pc + ADDR_W'(4));
    w_next_legal = addr_legal(w_next_pc, c_IMEM_BYTES);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_pend_target <= '0;
      r_fault       <= 1'b0;
    end else begin
      case (r_state)
        RUN, PEND: begin
          if (!stall) begin
            // The PC is only written when the destination is legal; an
            // illegal destination freezes the PC where it is.
            if (w_next_legal) begin
              r_pc    <= w_next_pc;
              r_state <= RUN;
            end else begin
              r_fault <= 1'b1;
              r_state <= FAULT;
            end
          end else if (br_taken) begin
            // Last redirect seen during a stall wins.
            r_pend_target <= br_target;
            r_state       <= PEND;
          end
        end
        FAULT: ;
        default: r_state <= FAULT;
      endcase
    end
  end

  if_id_reg #(
    .PC_W   (ADDR_W),
    .DATA_W (INSTR_W)
  ) u_if_id (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_load),
    .clr_valid (w_clr_valid),
    .valid_d   (w_valid_in),
    .pc_d      (r_pc),
    .instr_d   (imem_instr),
    .valid_q   (if_id_valid),
    .pc_q      (if_id_pc),
    .instr_q   (if_id_instr)
  );

  assign imem_addr = r_pc;
  assign fault     = r_fault;

endmodule
`default_nettype wire
